// File: rtl/smi_byte_data_unalign_if.sv
// ---------------------------------------------------------------------------
// smi_byte_data_unalign_if
// Bundles the three handshake channels of the SMI read-side byte unaligner:
//   setup : setupReady/byteOffset/byteCount  -> setupStop
//   axiIn : axiInReady/axiInData/axiInLast   -> axiInStop
//   smiOut: smiOutReady/smiOutEofc/smiOutData <- smiOutStop
// A transfer happens on a cycle with ready=1 and stop=0.
// Modports:
//   slave  - the unaligner itself (consumes setup and read beats, produces flits)
//   master - the environment around it (descriptor source, AXI read data
//            source and SMI flit sink)
// ---------------------------------------------------------------------------
interface smi_byte_data_unalign_if #(
    parameter int FlitWidth = 16
) ();
    logic                     setupReady;
    logic [7:0]               byteOffset;
    logic [15:0]              byteCount;
    logic                     setupStop;

    logic                     axiInReady;
    logic [FlitWidth*8-1:0]   axiInData;
    logic                     axiInLast;
    logic                     axiInStop;

    logic                     smiOutReady;
    logic [7:0]               smiOutEofc;
    logic [FlitWidth*8-1:0]   smiOutData;
    logic                     smiOutStop;

    modport slave (
        input  setupReady, byteOffset, byteCount,
        input  axiInReady, axiInData, axiInLast,
        input  smiOutStop,
        output setupStop, axiInStop,
        output smiOutReady, smiOutEofc, smiOutData
    );

    modport master (
        output setupReady, byteOffset, byteCount,
        output axiInReady, axiInData, axiInLast,
        output smiOutStop,
        input  setupStop, axiInStop,
        input  smiOutReady, smiOutEofc, smiOutData
    );
endinterface

// File: rtl/smi_byte_data_unalign.sv
// ---------------------------------------------------------------------------
// smi_byte_data_unalign
// Read-side byte unaligner. Takes lane-aligned AXI read beats of a transfer
// that starts at an arbitrary byte address, drops the leading offset bytes
// and repacks the payload into contiguous SMI flits. The final flit carries
// its valid byte count in smiOutEofc (1..FlitWidth, 0 = not last).
// Ports:
//   clk  - rising-edge clock
//   srst - asynchronous active-high reset
//   bus  - smi_byte_data_unalign_if.slave (setup, axiIn and smiOut channels)
// Structure: one halt-able input register per input channel, the framing
// FSM with offset/remaining/residue registers, and one output register.
// ---------------------------------------------------------------------------
module smi_byte_data_unalign #(
    parameter int FlitWidth = 16
) (
    input  logic                     clk,
    input  logic                     srst,
    smi_byte_data_unalign_if.slave   bus
);
    localparam int DW = FlitWidth * 8;
    localparam int OW = $clog2(FlitWidth);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRIME  = 3'd1,
        S_STREAM = 3'd2,
        S_FLUSH  = 3'd3,
        S_DRAIN  = 3'd4
    } state_e;

    // input registers
    logic            set_vld_q,  set_vld_d;
    logic [OW-1:0]   set_off_q,  set_off_d;
    logic [15:0]     set_cnt_q,  set_cnt_d;
    logic            beat_vld_q, beat_vld_d;
    logic [DW-1:0]   beat_data_q, beat_data_d;
    logic            beat_last_q, beat_last_d;

    // framing state
    state_e          state_q, state_d;
    logic [OW-1:0]   off_q, off_d;
    logic [15:0]     rem_q, rem_d;
    logic [DW-1:0]   res_q, res_d;
    logic            last_seen_q, last_seen_d;

    // output register
    logic            out_vld_q,  out_vld_d;
    logic [7:0]      out_eofc_q, out_eofc_d;
    logic [DW-1:0]   out_data_q, out_data_d;

    // control / datapath helpers
    logic            take_setup_s, take_beat_s, emit_s, out_free_s;
    logic            setup_load_s, beat_load_s, setup_stop_s, beat_stop_s;
    logic [7:0]      emit_eofc_s;
    logic [DW-1:0]   emit_data_s, upper_s, merged_s;
    logic [OW-1:0]   tail_s;
    logic [16:0]     rem17_s, tail17_s, fw17_s, rem_sub17_s;
    logic [15:0]     rem_sub_s;

    // The output register can take a new flit when empty or draining this cycle.
    assign out_free_s   = !out_vld_q || !bus.smiOutStop;

    // Input registers accept whenever they are empty or being emptied.
    assign setup_stop_s = set_vld_q && !take_setup_s;
    assign beat_stop_s  = beat_vld_q && !take_beat_s;
    assign setup_load_s = bus.setupReady && !setup_stop_s;
    assign beat_load_s  = bus.axiInReady && !beat_stop_s;

    // Backpressure is forced high while reset is asserted.
    assign bus.setupStop   = srst || setup_stop_s;
    assign bus.axiInStop   = srst || beat_stop_s;
    assign bus.smiOutReady = out_vld_q;
    assign bus.smiOutEofc  = out_eofc_q;
    assign bus.smiOutData  = out_data_q;

    // Byte-lane arithmetic: 17-bit compares keep rem free of wrap effects.
    assign tail_s      = '0 - off_q;                       // FW-off (mod FW)
    assign fw17_s      = 17'(FlitWidth);
    assign rem17_s     = {1'b0, rem_q};
    assign tail17_s    = fw17_s - {{(17-OW){1'b0}}, off_q};
    assign rem_sub_s   = rem_q - 16'(FlitWidth);
    assign rem_sub17_s = {1'b0, rem_sub_s};
    assign upper_s     = beat_data_q >> {off_q, 3'b000};
    // Residue fills the low FW-off lanes, the new beat's low off bytes go above.
    assign merged_s    = (off_q == '0) ? beat_data_q
                                       : (res_q | (beat_data_q << {tail_s, 3'b000}));

    // State and datapath registers.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            set_vld_q   <= 1'b0;
            set_off_q   <= '0;
            set_cnt_q   <= 16'd0;
            beat_vld_q  <= 1'b0;
            beat_data_q <= '0;
            beat_last_q <= 1'b0;
            state_q     <= S_IDLE;
            off_q       <= '0;
            rem_q       <= 16'd0;
            res_q       <= '0;
            last_seen_q <= 1'b0;
            out_vld_q   <= 1'b0;
            out_eofc_q  <= 8'd0;
            out_data_q  <= '0;
        end else begin
            set_vld_q   <= set_vld_d;
            set_off_q   <= set_off_d;
            set_cnt_q   <= set_cnt_d;
            beat_vld_q  <= beat_vld_d;
            beat_data_q <= beat_data_d;
            beat_last_q <= beat_last_d;
            state_q     <= state_d;
            off_q       <= off_d;
            rem_q       <= rem_d;
            res_q       <= res_d;
            last_seen_q <= last_seen_d;
            out_vld_q   <= out_vld_d;
            out_eofc_q  <= out_eofc_d;
            out_data_q  <= out_data_d;
        end
    end

    // Next-state logic: decides what to consume and emit in each state.
    always_comb begin
        state_d      = state_q;
        off_d        = off_q;
        rem_d        = rem_q;
        res_d        = res_q;
        last_seen_d  = last_seen_q;
        take_setup_s = 1'b0;
        take_beat_s  = 1'b0;
        emit_s       = 1'b0;
        emit_eofc_s  = 8'd0;
        emit_data_s  = merged_s;
        case (state_q)
            S_IDLE: begin
                if (set_vld_q) begin
                    take_setup_s = 1'b1;
                    off_d        = set_off_q;
                    rem_d        = set_cnt_q;
                    last_seen_d  = 1'b0;
                    if (set_cnt_q == 16'd0) begin
                        state_d = S_DRAIN;
                    end else if (set_off_q != '0) begin
                        state_d = S_PRIME;
                    end else begin
                        state_d = S_STREAM;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PRIME: begin
                // Leading beat only seeds the residue; output stall is irrelevant.
                if (beat_vld_q) begin
                    take_beat_s = 1'b1;
                    res_d       = upper_s;
                    last_seen_d = beat_last_q;
                    if (rem17_s <= tail17_s) begin
                        state_d = S_FLUSH;
                    end else if (beat_last_q) begin
                        // Burst ended early: flush only what this beat delivered.
                        rem_d   = tail17_s[15:0];
                        state_d = S_FLUSH;
                    end else begin
                        state_d = S_STREAM;
                    end
                end else begin
                    state_d = S_PRIME;
                end
            end
            S_STREAM: begin
                if (beat_vld_q && out_free_s) begin
                    take_beat_s = 1'b1;
                    emit_s      = 1'b1;
                    emit_data_s = merged_s;
                    res_d       = upper_s;
                    last_seen_d = beat_last_q;
                    if (rem17_s <= fw17_s) begin
                        emit_eofc_s = rem_q[7:0];
                        rem_d       = 16'd0;
                        state_d     = beat_last_q ? S_IDLE : S_DRAIN;
                    end else begin
                        emit_eofc_s = 8'd0;
                        rem_d       = rem_sub_s;
                        if ((off_q != '0) && (rem_sub17_s <= tail17_s)) begin
                            state_d = S_FLUSH;
                        end else if (beat_last_q) begin
                            // Burst ended early: this full flit is the last one.
                            emit_eofc_s = 8'(FlitWidth);
                            state_d     = S_IDLE;
                        end else begin
                            state_d = S_STREAM;
                        end
                    end
                end else begin
                    state_d = S_STREAM;
                end
            end
            S_FLUSH: begin
                if (out_free_s) begin
                    emit_s      = 1'b1;
                    emit_data_s = res_q;
                    emit_eofc_s = rem_q[7:0];
                    rem_d       = 16'd0;
                    state_d     = last_seen_q ? S_IDLE : S_DRAIN;
                end else begin
                    state_d = S_FLUSH;
                end
            end
            S_DRAIN: begin
                if (beat_vld_q) begin
                    take_beat_s = 1'b1;
                    state_d     = beat_last_q ? S_IDLE : S_DRAIN;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output and input-register next values.
    always_comb begin
        set_vld_d   = set_vld_q;
        set_off_d   = set_off_q;
        set_cnt_d   = set_cnt_q;
        beat_vld_d  = beat_vld_q;
        beat_data_d = beat_data_q;
        beat_last_d = beat_last_q;
        out_vld_d   = out_vld_q;
        out_eofc_d  = out_eofc_q;
        out_data_d  = out_data_q;

        if (setup_load_s) begin
            set_vld_d = 1'b1;
            set_off_d = OW'(bus.byteOffset & 8'(FlitWidth - 1));
            set_cnt_d = bus.byteCount;
        end else if (take_setup_s) begin
            set_vld_d = 1'b0;
        end else begin
            set_vld_d = set_vld_q;
        end

        if (beat_load_s) begin
            beat_vld_d  = 1'b1;
            beat_data_d = bus.axiInData;
            beat_last_d = bus.axiInLast;
        end else if (take_beat_s) begin
            beat_vld_d = 1'b0;
        end else begin
            beat_vld_d = beat_vld_q;
        end

        if (emit_s) begin
            out_vld_d  = 1'b1;
            out_eofc_d = emit_eofc_s;
            out_data_d = emit_data_s;
        end else if (!bus.smiOutStop) begin
            out_vld_d = 1'b0;
        end else begin
            out_vld_d = out_vld_q;
        end
    end
endmodule
